// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: a - b - bin over WIDTH cycles with one borrow flop.
// Define SERIAL_SUB_SAT_EN to clamp the parallel result to zero on final borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             diff_bit,
  output logic             diff_bit_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] aSh_q, bSh_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, busy_q, done_q, bout_q;
  logic             diffBit_q, diffBitValid_q;

  logic             dBit, borrow_d;
  logic [WIDTH-1:0] res_d, diffFinal_d;

  always_comb begin
    dBit     = aSh_q[0] ^ bSh_q[0] ^ borrow_q;
    borrow_d = (~aSh_q[0] & bSh_q[0]) | (~aSh_q[0] & borrow_q) | (bSh_q[0] & borrow_q);
  end

  // Each difference bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_d = dBit;
    end else begin : g_res_wn
      assign res_d = {dBit, res_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_SUB_SAT_EN
  assign diffFinal_d = borrow_d ? '0 : res_d;
`else
  assign diffFinal_d = res_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      aSh_q          <= '0;
      bSh_q          <= '0;
      res_q          <= '0;
      diff_q         <= '0;
      cnt_q          <= '0;
      borrow_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      bout_q         <= 1'b0;
      diffBit_q      <= 1'b0;
      diffBitValid_q <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      diffBitValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            aSh_q    <= a;
            bSh_q    <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            res_q    <= '0;
          end
        end
        RUN: begin
          aSh_q          <= aSh_q >> 1;
          bSh_q          <= bSh_q >> 1;
          borrow_q       <= borrow_d;
          res_q          <= res_d;
          cnt_q          <= cnt_q + 1'b1;
          diffBit_q      <= dBit;
          diffBitValid_q <= 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= diffFinal_d;
            bout_q  <= borrow_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign diff           = diff_q;
  assign bout           = bout_q;
  assign diff_bit       = diffBit_q;
  assign diff_bit_valid = diffBitValid_q;

endmodule
